// File: rtl/axi_dev_pkg.sv
// Shared definitions for the device-side write path: sequencer states,
// AXI response codes, burst type encodings and burst length limits.
package axi_dev_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT  = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } seq_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int MAX_BURST_BEATS = 16;

  // SLVERR and DECERR are the two responses that mean the burst failed.
  function automatic logic resp_is_error(input logic [1:0] code);
    return (code == RESP_SLVERR) || (code == RESP_DECERR);
  endfunction

endpackage

// File: rtl/write_request_sequencer_if.sv
// Bundle of the command, beat, write-master and response signals around the
// write request sequencer.
//
// Handshake rule for cmd_* and dat_*: a transfer happens on a rising devclock
// edge where valid and ready are both high. The source holds valid and its
// payload stable until that edge; ready never depends on valid.
interface write_request_sequencer_if #(
  parameter int BUSWIDTH = 32
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [3:0]          cmd_id;
  logic [31:0]         cmd_addr;
  logic [3:0]          cmd_len;
  logic [2:0]          cmd_size;
  logic [1:0]          cmd_burst;

  logic                dat_valid;
  logic                dat_ready;
  logic [BUSWIDTH-1:0] dat_data;

  logic [BUSWIDTH-1:0] Datain;
  logic                memoryWrite;
  logic [3:0]          AWWID;
  logic [3:0]          WWID;
  logic [31:0]         WADDR;
  logic [3:0]          WLEN;
  logic [2:0]          WSIZE;
  logic [1:0]          WBURST;
  logic [1:0]          WLOCK;
  logic [3:0]          WCACHE;
  logic [2:0]          WPROT;

  logic                rsp_valid;
  logic [1:0]          rsp_code;

  modport slave (
    input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
    input  dat_valid, dat_data, rsp_valid, rsp_code,
    output cmd_ready, dat_ready, Datain, memoryWrite,
    output AWWID, WWID, WADDR, WLEN, WSIZE, WBURST, WLOCK, WCACHE, WPROT
  );

  modport master (
    output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
    output dat_valid, dat_data, rsp_valid, rsp_code,
    input  cmd_ready, dat_ready, Datain, memoryWrite,
    input  AWWID, WWID, WADDR, WLEN, WSIZE, WBURST, WLOCK, WCACHE, WPROT
  );
endinterface

// File: rtl/outstanding_counter.sv
// Saturating up/down count of bursts issued but not yet answered.
// A decrement at zero is reported as underflow and does not move the count.
module outstanding_counter #(
  parameter int MAX = 4
) (
  input  logic       devclock,
  input  logic       ARESETn,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] count,
  output logic       limit_hit,
  output logic       underflow
);
  logic inc_ok;
  logic dec_ok;

  assign underflow = dec && (count == 3'd0);
  assign dec_ok    = dec && !underflow;
  assign inc_ok    = inc && (count != 3'd7);
  assign limit_hit = (count >= 3'(MAX));

  // Simultaneous inc and dec cancel; otherwise step by one.
  always_ff @(posedge devclock) begin
    if (!ARESETn) begin
      count <= 3'd0;
    end else begin
      case ({inc_ok, dec_ok})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/write_request_sequencer.sv
// Accepts one burst command plus its beats and replays each beat to the AXI
// write master as a single-cycle memoryWrite pulse, with the burst fields
// held from command accept until the next accept.
module write_request_sequencer
  import axi_dev_pkg::*;
#(
  parameter int BUSWIDTH        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int GAP             = 0
) (
  input  logic                     devclock,
  input  logic                     ARESETn,
  write_request_sequencer_if.slave bus,
  output logic [2:0]               outstanding,
  output logic                     busy,
  output logic                     err_sticky,
  output seq_state_t               state_dbg
);
  localparam int         BEAT_W   = $clog2(MAX_BURST_BEATS) + 1;
  localparam logic [1:0] GAP_LAST = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

  seq_state_t          state_q;
  seq_state_t          state_nxt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [1:0]          gap_cnt;
  logic [BUSWIDTH-1:0] datain_q;
  logic                mw_q;
  logic [3:0]          id_q;
  logic [31:0]         addr_q;
  logic [3:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic                cmd_hs;
  logic                dat_hs;
  logic                more_beats;
  logic                limit_hit;
  logic                underflow;

  // Ready signals depend only on state and the outstanding count, and are
  // held low while reset is asserted.
  assign bus.cmd_ready = ARESETn && (state_q == ST_IDLE) && !limit_hit;
  assign bus.dat_ready = ARESETn && (state_q == ST_BEAT);
  assign cmd_hs        = bus.cmd_valid && bus.cmd_ready;
  assign dat_hs        = bus.dat_valid && bus.dat_ready;

  // beat_cnt counts beats already sent, so it is at most 16 and never wraps.
  assign more_beats = (beat_cnt <= BEAT_W'(len_q));

  assign bus.Datain      = datain_q;
  assign bus.memoryWrite = mw_q;
  assign bus.AWWID       = id_q;
  assign bus.WWID        = id_q;
  assign bus.WADDR       = addr_q;
  assign bus.WLEN        = len_q;
  assign bus.WSIZE       = size_q;
  assign bus.WBURST      = burst_q;
  assign bus.WLOCK       = 2'b00;
  assign bus.WCACHE      = 4'b0000;
  assign bus.WPROT       = 3'b000;

  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

  outstanding_counter #(
    .MAX (MAX_OUTSTANDING)
  ) u_outstanding (
    .devclock  (devclock),
    .ARESETn   (ARESETn),
    .inc       (cmd_hs),
    .dec       (bus.rsp_valid),
    .count     (outstanding),
    .limit_hit (limit_hit),
    .underflow (underflow)
  );

  // State register.
  always_ff @(posedge devclock) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state: after each pulse (and optional gap) either fetch another
  // beat or return to IDLE once all len+1 beats have gone out.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_hs) state_nxt = ST_BEAT;
      end
      ST_BEAT: begin
        if (dat_hs) state_nxt = ST_PULSE;
      end
      ST_PULSE: begin
        if (GAP > 0)         state_nxt = ST_GAP;
        else if (more_beats) state_nxt = ST_BEAT;
        else                 state_nxt = ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = more_beats ? ST_BEAT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Burst fields, beat data, the one-cycle write pulse and the error flag.
  always_ff @(posedge devclock) begin
    if (!ARESETn) begin
      beat_cnt   <= '0;
      gap_cnt    <= 2'd0;
      datain_q   <= '0;
      mw_q       <= 1'b0;
      id_q       <= 4'd0;
      addr_q     <= 32'd0;
      len_q      <= 4'd0;
      size_q     <= 3'd0;
      burst_q    <= 2'd0;
      err_sticky <= 1'b0;
    end else begin
      if (cmd_hs) begin
        id_q     <= bus.cmd_id;
        addr_q   <= bus.cmd_addr;
        len_q    <= bus.cmd_len;
        size_q   <= bus.cmd_size;
        burst_q  <= bus.cmd_burst;
        beat_cnt <= '0;
      end
      if (dat_hs) begin
        datain_q <= bus.dat_data;
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
      // High only in the cycle right after a beat handshake.
      mw_q <= dat_hs;
      if (state_q == ST_PULSE)    gap_cnt <= 2'd0;
      else if (state_q == ST_GAP) gap_cnt <= gap_cnt + 2'd1;
      if (bus.rsp_valid && (underflow || resp_is_error(bus.rsp_code))) begin
        err_sticky <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_write_request_sequencer.sv
// Directed-plus-random bench for write_request_sequencer. Expected beats sit
// in a queue, outstanding/error follow a small integer model of the
// response rules, and a monitor checks every memoryWrite pulse.
module tb_write_request_sequencer;
  import axi_dev_pkg::*;

  localparam int BW   = 32;
  localparam int MAXO = 4;

  logic       devclock = 1'b0;
  logic       ARESETn  = 1'b0;
  logic [2:0] outstanding;
  logic       busy;
  logic       err_sticky;
  seq_state_t state_dbg;

  write_request_sequencer_if #(.BUSWIDTH(BW)) bus ();

  write_request_sequencer #(
    .BUSWIDTH        (BW),
    .MAX_OUTSTANDING (MAXO),
    .GAP             (0)
  ) dut (
    .devclock    (devclock),
    .ARESETn     (ARESETn),
    .bus         (bus),
    .outstanding (outstanding),
    .busy        (busy),
    .err_sticky  (err_sticky),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 devclock = ~devclock;

  initial begin
    #400000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  // scoreboard state
  int          n_cmp = 0;
  int          n_mis = 0;
  int          out_m = 0;
  logic        err_m = 1'b0;
  logic [BW-1:0] exp_q[$];
  logic [57:0] exp_fields = '0;
  int          cyc = 0;
  int          pulse_cyc_q[$];
  logic        prev_mw = 1'b0;

  always @(posedge devclock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [57:0] fields_now();
    return {bus.AWWID, bus.WWID, bus.WADDR, bus.WLEN, bus.WSIZE, bus.WBURST,
            bus.WLOCK, bus.WCACHE, bus.WPROT};
  endfunction

  // monitor: every pulse must carry the next expected beat and burst fields
  always @(negedge devclock) begin
    if (bus.memoryWrite) begin
      chk("no_back_to_back", prev_mw, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", bus.memoryWrite, 0);
      end else begin
        chk("beat_data", bus.Datain, exp_q.pop_front());
        chk("burst_fields", fields_now(), exp_fields);
      end
      pulse_cyc_q.push_back(cyc);
    end
    prev_mw = bus.memoryWrite;
  end

  // driver tasks (all start and end 1 time unit after a rising edge)
  task automatic do_reset(input int n);
    ARESETn = 1'b0;
    repeat (n) @(posedge devclock);
    #1;
    ARESETn = 1'b1;
    out_m = 0;
    err_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input bit with_rsp);
    logic [2:0] size;
    logic [1:0] burst;
    int n;
    size  = 3'($urandom_range(0, 5));
    burst = 2'($urandom_range(0, 2));
    bus.cmd_id = id; bus.cmd_addr = addr; bus.cmd_len = len;
    bus.cmd_size = size; bus.cmd_burst = burst; bus.cmd_valid = 1'b1;
    if (with_rsp) begin
      bus.rsp_code = RESP_OKAY;
      bus.rsp_valid = 1'b1;
    end
    n = 0;
    @(negedge devclock);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge devclock);
      n++;
    end
    chk("cmd_accept", bus.cmd_ready, 1);
    @(posedge devclock);
    #1;
    bus.cmd_valid = 1'b0;
    bus.rsp_valid = 1'b0;
    if (with_rsp) begin
      if (out_m == 0) err_m = 1'b1;
      else out_m--;
    end
    out_m++;
    exp_fields = {id, id, addr, len, size, burst, 9'd0};
    chk("dat_ready_after_accept", bus.dat_ready, 1);
    chk("outstanding_after_accept", outstanding, out_m);
  endtask

  task automatic send_beats(input int n, input int max_stall);
    for (int i = 0; i < n; i++) begin
      int stall;
      int k;
      logic [BW-1:0] d;
      stall = $urandom_range(0, max_stall);
      for (int s = 0; s < stall; s++) begin
        bus.dat_valid = 1'b0;
        @(posedge devclock);
        #1;
      end
      d = $urandom;
      bus.dat_data = d;
      bus.dat_valid = 1'b1;
      exp_q.push_back(d);
      k = 0;
      @(negedge devclock);
      while (!bus.dat_ready && k < 100) begin
        @(negedge devclock);
        k++;
      end
      chk("dat_accept", bus.dat_ready, 1);
      @(posedge devclock);
      #1;
    end
    bus.dat_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge devclock);
    while (busy && k < 200) begin
      @(negedge devclock);
      k++;
    end
    chk("burst_done", busy, 0);
    chk("beats_drained", exp_q.size(), 0);
    @(posedge devclock);
    #1;
  endtask

  task automatic rsp(input logic [1:0] code);
    bus.rsp_code = code;
    bus.rsp_valid = 1'b1;
    @(posedge devclock);
    if (out_m == 0) err_m = 1'b1;
    else out_m--;
    if (code[1]) err_m = 1'b1;
    #1;
    bus.rsp_valid = 1'b0;
    chk("outstanding_after_rsp", outstanding, out_m);
    chk("err_after_rsp", err_sticky, err_m);
  endtask

  initial begin
    logic [3:0] len;
    bus.cmd_valid = 1'b0; bus.cmd_id = '0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.cmd_size = '0; bus.cmd_burst = '0; bus.dat_valid = 1'b0; bus.dat_data = '0;
    bus.rsp_valid = 1'b0; bus.rsp_code = '0;

    // reset: ready forced low even with valid asserted, outputs cleared
    bus.cmd_valid = 1'b1;
    bus.dat_valid = 1'b1;
    repeat (3) @(posedge devclock);
    @(negedge devclock);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_dat_ready", bus.dat_ready, 0);
    chk("rst_mw", bus.memoryWrite, 0);
    chk("rst_datain", bus.Datain, 0);
    chk("rst_fields", fields_now(), 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_sticky, 0);
    bus.cmd_valid = 1'b0;
    bus.dat_valid = 1'b0;
    @(posedge devclock);
    #1;
    ARESETn = 1'b1;
    @(negedge devclock);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    @(posedge devclock);
    #1;

    // single-beat burst, id 3 at 0x100
    send_cmd(4'd3, 32'h100, 4'd0, 1'b0);
    bus.dat_data = 32'hA5A5A5A5;
    bus.dat_valid = 1'b1;
    exp_q.push_back(32'hA5A5A5A5);
    @(negedge devclock);
    chk("t1_dat_ready", bus.dat_ready, 1);
    @(posedge devclock);
    #1;
    bus.dat_valid = 1'b0;
    @(negedge devclock);
    chk("t1_pulse", bus.memoryWrite, 1);
    chk("t1_wwid", bus.WWID, 3);
    chk("t1_awwid", bus.AWWID, 3);
    chk("t1_waddr", bus.WADDR, 32'h100);
    chk("t1_outstanding", outstanding, 1);
    @(negedge devclock);
    chk("t1_single_pulse", bus.memoryWrite, 0);
    chk("t1_back_idle", busy, 0);
    @(posedge devclock);
    #1;

    // 16-beat burst with data always valid: pulses exactly 2 cycles apart
    pulse_cyc_q.delete();
    send_cmd(4'($urandom), $urandom, 4'd15, 1'b0);
    send_beats(16, 0);
    wait_idle();
    chk("t2_pulse_count", pulse_cyc_q.size(), 16);
    for (int i = 1; i < pulse_cyc_q.size(); i++) begin
      chk("t2_pulse_spacing", pulse_cyc_q[i] - pulse_cyc_q[i-1], 2);
    end
    rsp(RESP_OKAY);
    rsp(RESP_EXOKAY);

    // fill to the limit, then a response reopens cmd_ready a cycle later
    for (int b = 0; b < MAXO; b++) begin
      len = 4'($urandom_range(0, 3));
      send_cmd(4'(b), $urandom, len, 1'b0);
      send_beats(int'(len) + 1, 2);
      wait_idle();
    end
    chk("t3_full_count", outstanding, out_m);
    bus.cmd_id = 4'd9; bus.cmd_addr = $urandom; bus.cmd_len = 4'd0; bus.cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge devclock);
      chk("t3_full_blocks", bus.cmd_ready, 0);
      @(posedge devclock);
      #1;
    end
    bus.cmd_valid = 1'b0;
    chk("t3_no_accept", outstanding, out_m);
    bus.rsp_code = RESP_OKAY;
    bus.rsp_valid = 1'b1;
    @(negedge devclock);
    chk("t3_ready_same_cycle", bus.cmd_ready, 0);
    @(posedge devclock);
    out_m--;
    #1;
    bus.rsp_valid = 1'b0;
    @(negedge devclock);
    chk("t3_ready_next_cycle", bus.cmd_ready, 1);
    @(posedge devclock);
    #1;
    send_cmd(4'd9, $urandom, 4'd1, 1'b0);
    send_beats(2, 1);
    wait_idle();
    while (out_m > 0) rsp(RESP_OKAY);

    // random soak: random lengths, stalls and interleaved good responses
    for (int b = 0; b < 12; b++) begin
      while (out_m > 0 && (out_m == MAXO || $urandom_range(0, 1) == 1)) begin
        rsp(2'($urandom_range(0, 1)));
      end
      len = 4'($urandom_range(0, 15));
      send_cmd(4'($urandom), $urandom, len, 1'b0);
      send_beats(int'(len) + 1, 2);
      wait_idle();
    end
    while (out_m > 0) rsp(RESP_OKAY);
    chk("soak_err_clear", err_sticky, err_m);

    // accept and response on the same edge leave the count unchanged
    send_cmd(4'd5, 32'h2000, 4'd0, 1'b0);
    send_beats(1, 0);
    wait_idle();
    send_cmd(4'd6, 32'h3000, 4'd2, 1'b1);
    chk("t5_same_edge_count", outstanding, 1);
    send_beats(3, 1);
    wait_idle();
    rsp(RESP_OKAY);

    // unmatched response, then reset, then a SLVERR response
    rsp(RESP_OKAY);
    repeat (3) @(posedge devclock);
    #1;
    chk("t4_err_stays", err_sticky, 1);
    chk("t4_count_zero", outstanding, 0);
    do_reset(2);
    chk("t4_reset_clears_err", err_sticky, 0);
    send_cmd(4'd7, 32'h40, 4'd0, 1'b0);
    send_beats(1, 0);
    wait_idle();
    rsp(RESP_SLVERR);
    repeat (4) @(posedge devclock);
    #1;
    chk("t4_slverr_sticky", err_sticky, 1);

    // reset mid-burst after beat 3 of 8 abandons the burst
    send_cmd(4'd8, 32'h5000, 4'd7, 1'b0);
    send_beats(3, 0);
    @(posedge devclock);
    #1;
    bus.dat_data = $urandom;
    bus.dat_valid = 1'b1;
    ARESETn = 1'b0;
    @(negedge devclock);
    chk("t6_dat_ready_in_reset", bus.dat_ready, 0);
    @(negedge devclock);
    chk("t6_mw", bus.memoryWrite, 0);
    chk("t6_datain", bus.Datain, 0);
    chk("t6_fields", fields_now(), 0);
    chk("t6_outstanding", outstanding, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", err_sticky, 0);
    @(posedge devclock);
    #1;
    ARESETn = 1'b1;
    out_m = 0;
    err_m = 1'b0;
    exp_q.delete();
    repeat (6) begin
      @(negedge devclock);
      chk("t6_no_beat_ready", bus.dat_ready, 0);
      @(posedge devclock);
      #1;
    end
    bus.dat_valid = 1'b0;
    chk("t6_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/write_request_sequencer.md
# write_request_sequencer

Device-side burst sequencer sitting directly upstream of the AXI write master on the `devclock` domain. It accepts one burst command and its data beats over valid/ready streams, then replays each beat to the write master as a one-cycle `memoryWrite` pulse, with `Datain` and the burst fields held stable. It also tracks outstanding bursts against returned write responses and throttles new commands at a configurable limit.

## Interface
- `BUSWIDTH`, 32, data beat width
- `MAX_OUTSTANDING`, 4, bursts allowed without a response (1..7)
- `GAP`, 0, extra idle cycles forced after each `memoryWrite` pulse (0..3)

- `devclock` in 1: clock (Already decided)
- `ARESETn` in 1: reset, synchronous, active-low (Already decided)
- `cmd_valid` in 1 / `cmd_ready` out 1: burst command handshake
- `cmd_id` in 4, `cmd_addr` in 32, `cmd_len` in 4 (beats−1), `cmd_size` in 3, `cmd_burst` in 2: command fields
- `dat_valid` in 1 / `dat_ready` out 1 / `dat_data` in BUSWIDTH: beat stream
- `Datain` out BUSWIDTH, `memoryWrite` out 1: beat to write master
- `AWWID`, `WWID` out 4; `WADDR` out 32; `WLEN` out 4; `WSIZE` out 3; `WBURST` out 2; `WLOCK` out 2; `WCACHE` out 4; `WPROT` out 3: burst fields to write master
- `rsp_valid` in 1 / `rsp_code` in 2: one pulse per completed burst
- `outstanding` out 3: bursts issued minus responses received
- `busy` out 1: state ≠ IDLE
- `err_sticky` out 1: a bad response or an unmatched response was seen

## Operation
- States: IDLE, BEAT, PULSE, GAP.
- **IDLE**
  - `cmd_ready = (outstanding < MAX_OUTSTANDING)`.
  - On handshake: register all fields, set `AWWID = WWID = cmd_id`, clear `beat_cnt` (5 bits), `outstanding`+1, go to BEAT.
- **BEAT**
  - `dat_ready = 1`.
  - On handshake: `Datain <= dat_data`, `memoryWrite <= 1`, `beat_cnt`+1, go to PULSE.
- **PULSE**
  - `memoryWrite <= 0`.
  - Next state: GAP if `GAP > 0`; else BEAT if `beat_cnt <= WLEN`; else IDLE.
- **GAP**
  - Count `GAP` cycles with `memoryWrite` low.
  - Then apply the same BEAT/IDLE decision as PULSE.
- Each burst emits exactly `cmd_len + 1` pulses. `cmd_len = 15` gives 16 beats, and `beat_cnt` must not wrap.
- Burst fields stay constant from command accept until the next accept. The address does not advance per beat; the downstream stages handle address increment.
- `WLOCK`, `WCACHE`, `WPROT` are tied to 0.
- Responses:
  - `rsp_valid` decrements `outstanding`.
  - An accept and a response in the same cycle leave `outstanding` unchanged.
  - `rsp_valid` while `outstanding == 0` is ignored for the count and sets `err_sticky`.
  - `rsp_code` of 2'b10 or 2'b11 sets `err_sticky`.
  - Only reset clears `err_sticky`.
- `cmd_ready` and `dat_ready` are combinational from state and counter only, never from `cmd_valid` or `dat_valid`.

## Timing
- Reset (`ARESETn` low at an edge):
  - State returns to IDLE; all registered outputs, `outstanding`, `beat_cnt` and `err_sticky` clear to 0.
  - `cmd_ready` and `dat_ready` are forced to 0 while `ARESETn` is low.
- Reset mid-burst abandons the burst with no further pulses. An in-progress `memoryWrite` drops at that edge.
- Latency:
  - Command accepted at edge E0 → `dat_ready` high in cycle E0+.
  - Data accepted at E1 → `memoryWrite` high for exactly the cycle after E1.
- Pulse spacing: at least 2 + `GAP` cycles. `memoryWrite` is never high on two consecutive cycles; the write master is edge-qualified.
- Back-to-back bursts:
  - The last pulse's PULSE/GAP cycle returns to IDLE, so the next command can be accepted on the following edge.
  - Minimum gap between bursts is 1 IDLE cycle.
- Full: with `outstanding == MAX_OUTSTANDING`, `cmd_ready = 0`. A response in that cycle raises `cmd_ready` the next cycle, not the same cycle.
- `dat_valid` low in BEAT stalls indefinitely with no pulse.

## Structure
- Shared package `axi_dev_pkg`:
  - State enum.
  - Response codes OKAY/EXOKAY/SLVERR/DECERR.
  - Burst type constants FIXED/INCR/WRAP.
  - `MAX_BURST_BEATS = 16`.
- One natural sub-module, `outstanding_counter`: a saturating up/down counter with `inc`, `dec`, `limit_hit` and `underflow` outputs.

## Test plan
- Reset, then `cmd_len = 0`, id 3, addr 0x100, `dat_data` 0xA5A5A5A5 → exactly one `memoryWrite` pulse one cycle after data accept; `WWID = AWWID = 3`; `WADDR = 0x100`; `outstanding = 1`.
- `cmd_len = 15`, `dat_valid` always high, `GAP = 0` → 16 single-cycle pulses spaced 2 cycles apart, data in order, then back to IDLE.
- Issue 4 bursts with no responses → 5th `cmd_valid` sees `cmd_ready = 0`; one `rsp_valid` with OKAY → `cmd_ready = 1` the next cycle.
- `rsp_code = 2'b10`, then separately `rsp_valid` with `outstanding = 0` → `err_sticky = 1` and it stays set; count stays 0.
- Command accept and `rsp_valid` on the same edge → `outstanding` unchanged; `ARESETn` low mid-burst after beat 3 of 8 → no further pulses and all outputs 0 next cycle.
